avalon_copy_master: RTL and testbench
=====================================

Name: avalon_copy_master

Overview:
- Avalon-MM master that copies a block of 16-bit words from one word address range to another, through the system interconnect.
- Initiator counterpart to the single-port on-chip memory slave: it drives address, read, write, writedata and byteenable, and honours waitrequest and readdatavalid.
- Controlled by a start/length command port from local control logic. Moves one word at a time, with a single outstanding transaction.

Parameters:
- ADDR_W, 14, word-address width of the master port and of the pointers.
- DATA_W, 16, data width; must be a multiple of 8.
- LEN_W, 14, width of the word-count command and of the progress counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  LEN_W  number of words to copy.
- abort  in  1  request to stop at the next word boundary.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the command finishes, whether completed or aborted.
- count  out  LEN_W  words fully written in the current or last command.
- avm_address  out  ADDR_W  master address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  byte enables; always all ones.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data qualifier.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; busy, done, avm_read and avm_write all 0; avm_address, avm_writedata, count and internal pointers all 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - On start=1, latch src_addr, dst_addr and length; clear count and abort_pending.
  - Next state is FINISH if length==0, otherwise RD_REQ.
  - abort in IDLE is ignored.
- RD_REQ:
  - Drive avm_read=1 with avm_address=src_ptr.
  - Hold both unchanged while avm_waitrequest=1 (Avalon hold rule; never withdraw a pending request).
  - On a cycle with avm_waitrequest=0:
    - if avm_readdatavalid=1 in the same cycle, capture avm_readdata and go to WR_REQ;
    - otherwise go to RD_WAIT.
- RD_WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1, capture avm_readdata into the data register and go to WR_REQ.
  - Wait indefinitely; there is no timeout.
- readdatavalid asserted in IDLE, WR_REQ or FINISH is ignored.
- WR_REQ:
  - Drive avm_write=1, avm_address=dst_ptr, avm_writedata=data register.
  - Hold while avm_waitrequest=1.
  - On acceptance: src_ptr+1, dst_ptr+1, count+1, remaining-1.
  - Next state is FINISH if remaining reaches 0 or abort_pending is set (including abort sampled in this same cycle); otherwise RD_REQ.
- FINISH: done=1 for exactly one cycle, busy=1; next state IDLE.
- Pointer arithmetic: pointers wrap modulo 2^ADDR_W (0x3FFF+1 becomes 0x0000). No error is flagged.
- abort:
  - Any cycle with busy=1 sets abort_pending.
  - An in-flight read completes and its word is written before stopping; count reflects the words written.
- start while busy is ignored.
- count holds its value after FINISH until the next accepted start.
- Throughput: with zero wait states and read latency 1, 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ). With zero-latency readdatavalid, 2 cycles per word.
- avm_read and avm_write are never asserted together.
- Reset mid-transfer aborts immediately. Outputs return to reset values asynchronously; no done pulse is produced.

Decomposition:
- Package avalon_copy_pkg holds the state enumeration (IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH) and the default width constants (ADDR_W=14, DATA_W=16, LEN_W=14).
- Single module; no natural sub-module. The FSM and datapath (pointers, remaining, data register) are small enough to stay together.

Test Plan:
- Basic copy: memory model with read latency 1, no waitrequest; src=0x0010, dst=0x0100, length=4, source data A0..A3.
  -> dst 0x0100..0x0103 = A0..A3; done pulse 12 cycles after start; count=4; busy low the cycle after done.
- Zero length: start with length=0.
  -> FINISH next cycle, done pulse, no avm_read/avm_write ever asserted, count=0.
- Back-pressure: waitrequest high for 3 cycles on every read and every write; length=2.
  -> avm_address, avm_read, avm_write and avm_writedata stable throughout each stall; both words correct; done once.
- Address wrap: src=0x3FFE, dst=0x1FFF, length=3.
  -> reads at 0x3FFE, 0x3FFF, 0x0000; writes at 0x1FFF, 0x2000, 0x2001.
- Abort: length=10; abort pulsed during the 3rd word's RD_WAIT.
  -> 3rd word still written; done pulse; count=3; no further reads issued. A start in the same window is ignored.
- Reset mid-operation: reset_n low during WR_REQ.
  -> avm_write=0, busy=0 and count=0 immediately; no done pulse. A new command after reset completes correctly.

Source files
------------

// File: rtl/avalon_copy_pkg.sv
// rtl/avalon_copy_pkg.sv - state encoding and default widths for the Avalon-MM copy master
package avalon_copy_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FINISH  = 3'd4
    } copy_state_e;

endpackage

// File: rtl/avalon_copy_master.sv
// rtl/avalon_copy_master.sv - Avalon-MM master copying a block of words, one outstanding transaction
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, src_addr, dst_addr,
//   length, abort                command port (start sampled only when idle)
//   busy, done, count            status: busy outside IDLE, one-cycle done, words written
//   avm_*                        Avalon-MM master port (address/read/write/writedata/byteenable,
//                                readdata/readdatavalid/waitrequest)
module avalon_copy_master
    import avalon_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    count,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                avm_waitrequest
);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              abort_pend_q, abort_pend_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            count_q      <= '0;
            data_q       <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            count_q      <= count_d;
            data_q       <= data_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        count_d      = count_q;
        data_d       = data_q;
        abort_pend_d = abort_pend_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    rem_d        = length;
                    count_d      = '0;
                    abort_pend_d = 1'b0;
                    state_d      = (length == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    // Zero-latency slaves return data in the accepting cycle.
                    if (avm_readdatavalid) begin
                        data_d  = avm_readdata;
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    data_d  = avm_readdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    count_d = count_q + LEN_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    // An abort arriving in the accepting cycle still stops here.
                    if (rem_q == LEN_W'(1) || abort_pend_q || abort) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && abort) begin
            abort_pend_d = 1'b1;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FINISH);
    assign count          = count_q;
    assign avm_read       = (state_q == RD_REQ);
    assign avm_write      = (state_q == WR_REQ);
    assign avm_address    = (state_q == WR_REQ) ? dst_q : src_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = '1;

endmodule

// File: tb/tb_avalon_copy_master.sv
// tb/tb_avalon_copy_master.sv - randomized self-checking bench for avalon_copy_master
module tb_avalon_copy_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] src_addr = '0;
    logic [13:0] dst_addr = '0;
    logic [13:0] length = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [13:0] count;
    logic [13:0] avm_address;
    logic        avm_read, avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;

    avalon_copy_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .length            (length),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .count             (count),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave memory and the reference image it is compared against.
    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    logic [13:0] rd_log[$];
    logic [13:0] wr_log[$];
    int          rd_acc_cnt = 0;
    int          lat = 1;
    int          ws_mode = 0;     // >=0 fixed wait states, <0 random 0..2

    int          wait_left = 0;
    bit          in_req = 0;
    int          pend = 0;
    logic [15:0] pend_data = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_bus = '0;

    // Avalon slave: responses decided just after the rising edge, acceptance sampled on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                in_req = 0; pend = 0; wait_left = 0;
                avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (avm_read || avm_write) begin
                    if (!in_req) begin
                        in_req    = 1;
                        wait_left = (ws_mode < 0) ? int'($urandom_range(0, 2)) : ws_mode;
                    end
                    if (wait_left > 0) begin
                        avm_waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        if (avm_read && lat == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = mem[avm_address];
                        end
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
            end else begin
                check_eq("rw_exclusive", 64'(avm_read && avm_write), 64'(0));
                if (prev_stall)
                    check_eq("stall_hold", 64'({avm_address, avm_read, avm_write, avm_writedata}), 64'(prev_bus));
                prev_stall = (avm_read || avm_write) && avm_waitrequest;
                prev_bus   = {avm_address, avm_read, avm_write, avm_writedata};
                if (avm_read && !avm_waitrequest) begin
                    rd_log.push_back(avm_address);
                    rd_acc_cnt++;
                    in_req = 0;
                    if (lat > 0) begin
                        pend      = lat;
                        pend_data = mem[avm_address];
                    end
                end
                if (avm_write && !avm_waitrequest) begin
                    wr_log.push_back(avm_address);
                    mem[avm_address] = avm_writedata;
                    in_req = 0;
                end
            end
        end
    end

    task automatic run_cmd(input logic [13:0] s, input logic [13:0] d, input int len,
                           input int lat_i, input int ws_i, input int abort_word,
                           input bit chk_time, input string name);
        int          n_exp;
        int          cycles;
        int          diffs;
        bit          aborted;
        logic [13:0] a;
        n_exp = (abort_word > 0 && abort_word < len) ? abort_word : len;
        lat = lat_i;
        ws_mode = ws_i;
        for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < n_exp; i++) begin
            a = d + 14'(i);
            ref_mem[a] = ref_mem[14'(s + 14'(i))];
        end
        rd_log.delete();
        wr_log.delete();
        rd_acc_cnt = 0;

        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; length = 14'(len);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_busy"}, 64'(busy), 64'(1));
        cycles = 0;
        aborted = 0;
        while (!done && cycles < 3000) begin
            if (abort_word > 0 && !aborted && rd_acc_cnt == abort_word) begin
                abort = 1'b1;
                start = 1'b1;           // must be ignored while busy
                src_addr = s + 14'd777;
                length = 14'd1;
                aborted = 1;
            end else begin
                abort = 1'b0;
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        abort = 1'b0;
        start = 1'b0;
        check_eq({name, "_done"}, 64'(done), 64'(1));
        check_eq({name, "_count"}, 64'(count), 64'(n_exp));
        if (chk_time)
            check_eq({name, "_latency"}, 64'(cycles), 64'(n_exp * (2 + 2 * ws_i + lat_i)));
        @(posedge clk); #1;
        check_eq({name, "_done_pulse"}, 64'(done), 64'(0));
        check_eq({name, "_idle"}, 64'(busy), 64'(0));
        check_eq({name, "_count_hold"}, 64'(count), 64'(n_exp));
        check_eq({name, "_n_reads"}, 64'(rd_log.size()), 64'(n_exp));
        check_eq({name, "_n_writes"}, 64'(wr_log.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < rd_log.size() && i < wr_log.size(); i++) begin
            check_eq({name, "_rd_addr"}, 64'(rd_log[i]), 64'(14'(s + 14'(i))));
            check_eq({name, "_wr_addr"}, 64'(wr_log[i]), 64'(14'(d + 14'(i))));
        end
        diffs = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check_eq({name, "_mem"}, 64'(diffs), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          cycles;
        bit          saw_done;
        logic [13:0] s, d;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);

        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_rw", 64'({avm_read, avm_write}), 64'(0));
        check_eq("rst_addr", 64'(avm_address), 64'(0));
        check_eq("rst_wdata", 64'(avm_writedata), 64'(0));
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("byteenable", 64'(avm_byteenable), 64'(2'b11));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 4; i++) mem[14'h0010 + 14'(i)] = 16'hA000 + 16'(i);
        run_cmd(14'h0010, 14'h0100, 4, 1, 0, 0, 1, "basic");
        for (int i = 0; i < 4; i++)
            check_eq("basic_data", 64'(mem[14'h0100 + 14'(i)]), 64'(16'hA000 + 16'(i)));
        run_cmd(14'h0200, 14'h0300, 0, 1, 0, 0, 1, "zero_len");
        run_cmd(14'h0400, 14'h0500, 2, 1, 3, 0, 1, "backpressure");
        run_cmd(14'h3FFE, 14'h1FFF, 3, 1, 0, 0, 1, "wrap");
        run_cmd(14'h0600, 14'h0700, 10, 1, 0, 3, 0, "abort");
        run_cmd(14'h0800, 14'h0900, 5, 0, 0, 0, 1, "lat0");

        for (int k = 0; k < 10; k++) begin
            int ws;
            ws = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 2));
            run_cmd(14'($urandom), 14'($urandom), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 2)), ws, 0, (ws >= 0), "random");
        end

        // Reset while a write is being presented.
        lat = 1; ws_mode = 2;
        @(posedge clk); #1;
        start = 1'b1; src_addr = 14'h0A00; dst_addr = 14'h0B00; length = 14'd6;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (!avm_write && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("rst_mid_reach_write", 64'(avm_write), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_write", 64'(avm_write), 64'(0));
        check_eq("rst_mid_busy", 64'(busy), 64'(0));
        check_eq("rst_mid_count", 64'(count), 64'(0));
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        check_eq("rst_mid_no_done", 64'(saw_done), 64'(0));
        s = 14'h0C00; d = 14'h0D00;
        run_cmd(s, d, 6, 1, 0, 0, 1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
